// File: rtl/key_step_gen_pkg.sv
// Shared state type and constants for the key step generator.
package key_pkg;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  localparam int unsigned MIN_DEBOUNCE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE        = ST_IDLE,
    PRESS_CHK   = ST_PRESS_CHK,
    HELD        = ST_HELD,
    RELEASE_CHK = ST_RELEASE_CHK
  } key_state_t;

endpackage

// File: rtl/key_step_gen_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, reset value set per instance.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_step_gen.sv
// Synchronise, debounce and pulse-convert a board key; one oStep per accepted press.
// Optional auto-repeat while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_step_gen
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic iKey,
  output logic oStep,
  output logic oLevel
);

  localparam int unsigned DB = (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) ?
                               MIN_DEBOUNCE_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W = $clog2(DB + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB - 2);
  localparam logic ACT_LOW = (ACTIVE_LOW != 0);

  logic             key_sync;
  logic             k;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .RESET_VAL(ACT_LOW)
  ) u_sync (
    .CLK  (CLK),
    .rst_n(rst_n),
    .d    (iKey),
    .q    (key_sync)
  );

  assign k = key_sync ^ ACT_LOW;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rcnt;
  logic             rep_phase;
`else
  if (REPEAT_DELAY == 0 && REPEAT_PERIOD == 0) begin : g_no_repeat
  end
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      oStep  <= 1'b0;
      oLevel <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt      <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      oStep <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      // Repeat timing only survives while HELD; every other path restarts it.
      rcnt      <= '0;
      rep_phase <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (k) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!k) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= HELD;
            cnt    <= '0;
            oStep  <= 1'b1;
            oLevel <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!k) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rcnt == (rep_phase ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
            oStep     <= 1'b1;
            rcnt      <= '0;
            rep_phase <= 1'b1;
          end else begin
            rcnt      <= rcnt + 1'b1;
            rep_phase <= rep_phase;
          end
`endif
        end
        RELEASE_CHK: begin
          if (k) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            oLevel <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
